lcd_bus_arbiter: RTL

Shares the single ST7920-class 12864 LCD parallel bus between two byte-level requesters, e.g. the block-graphics writer and a text/status writer. Each transfer is one command or data byte with a full setup / enable-high / hold cycle generated from the 50 MHz system clock. The block sits between the LCD content generators and the LCD pins, and it is the only driver of `lcd_rs`, `lcd_rw`, `lcd_en` and `lcd_data`.

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_phase_timer.sv | 27 ++
 rtl/lcd_bus_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the ST7920-class LCD bus logic:
// transfer state encoding, common controller commands and the default phase length.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_EN_HIGH = 2'd2,
    ST_HOLD    = 2'd3
  } lcd_state_t;

  // 50 us per bus phase at a 50 MHz system clock
  localparam int unsigned CLK_DIV_DEFAULT = 2500;

  localparam logic [7:0] FUNC_BASIC      = 8'h30;
  localparam logic [7:0] ENTRY_MODE      = 8'h06;
  localparam logic [7:0] DISP_ON         = 8'h0C;
  localparam logic [7:0] FUNC_EXT_GFX    = 8'h36;
  localparam logic [7:0] GDRAM_ADDR_BASE = 8'h80;

endpackage

// File: rtl/lcd_phase_timer.sv
// Bus phase timer: counts 0..CLK_DIV-1 and flags the last cycle of a phase.
// The counter returns to zero whenever clear is high.
module lcd_phase_timer #(
  parameter int unsigned CLK_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic phase_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign phase_done = (cnt == CNT_LAST);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter and write-cycle generator for the LCD parallel bus.
// Define LCD_ARB_LOCK_EN to let a requester keep the bus across consecutive transfers.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  input  logic       lock0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  input  logic       lock1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  lcd_state_t state, next_state;

  logic phase_done;
  logic timer_clear;
  logic arb_en;
  logic grant_valid;
  logic grant_sel;
  logic grant_idx;
  logic last_grant;
  logic finish;
  logic en_q;

  // The counter sits at zero through IDLE so SETUP always starts from a full phase.
  assign timer_clear = (state == ST_IDLE) || phase_done;

  lcd_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .phase_done (phase_done)
  );

  assign finish = (state == ST_HOLD) && phase_done;
  assign arb_en = (state == ST_IDLE) && !ack0 && !ack1;

`ifdef LCD_ARB_LOCK_EN
  logic lock_flag;
  logic owner_req;

  assign owner_req = grant_idx ? req1 : req0;

  // Set from the owner's lock input as its transfer ends; the first arbitration
  // cycle afterwards always consumes it, whether or not the owner is requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_flag <= 1'b0;
    end else if (finish) begin
      lock_flag <= grant_idx ? lock1 : lock0;
    end else if (arb_en) begin
      lock_flag <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (arb_en) begin
`ifdef LCD_ARB_LOCK_EN
      if (lock_flag && owner_req) begin
        grant_valid = 1'b1;
        grant_sel   = grant_idx;
      end else
`endif
      if (req0 && req1) begin
        grant_valid = 1'b1;
        grant_sel   = ~last_grant;
      end else if (req0 || req1) begin
        grant_valid = 1'b1;
        grant_sel   = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (grant_valid) next_state = ST_SETUP;
      ST_SETUP:   if (phase_done)  next_state = ST_EN_HIGH;
      ST_EN_HIGH: if (phase_done)  next_state = ST_HOLD;
      ST_HOLD:    if (phase_done)  next_state = ST_IDLE;
      default:                     next_state = ST_IDLE;
    endcase
  end

  // Pin-facing outputs are registered so the LCD never sees decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      en_q       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      grant_idx  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      en_q <= (next_state == ST_EN_HIGH);
      ack0 <= finish && !grant_idx;
      ack1 <= finish &&  grant_idx;
      if (grant_valid) begin
        lcd_rs     <= grant_sel ? rs1 : rs0;
        lcd_data   <= grant_sel ? data1 : data0;
        grant_idx  <= grant_sel;
        last_grant <= grant_sel;
      end
    end
  end

  assign lcd_en = en_q;
  assign lcd_rw = 1'b0;
  assign busy   = (state != ST_IDLE);

endmodule
